sonar_sequencer: RTL and testbench

SONAR_SEQUENCER -- requirements
Module: sonar_sequencer

---
 rtl/sonar_sequencer.sv | 178 +++++++++++++++++
 tb/tb_sonar_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sonar_sequencer.sv
// Sequences up to six ultrasonic rangers: triggers each enabled sonar from the
// highest index down, times its echo in microseconds and hands out one result per sonar.
module sonar_sequencer #(
  parameter int CLK_MHZ    = 50,
  parameter int TRIG_US    = 10,
  parameter int RISE_TO_US = 1000,
  parameter int MAX_US     = 30000,
  parameter int GAP_US     = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_wr,
  input  logic [5:0]  cfg_mask,
  output logic [5:0]  trig,
  input  logic [5:0]  echo,
  output logic [27:0] res_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        busy,
  output logic        done,
  output logic [2:0]  state_dbg
);

  // Result handshake: res_data is held stable while res_valid is high; the
  // result is consumed on the rising edge where res_valid && res_ready.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    OUT       = 3'd4,
    GAP       = 3'd5
  } state_t;

  localparam logic [15:0] PRE_LAST  = 16'(CLK_MHZ - 1);
  localparam logic [15:0] TRIG_LAST = 16'(TRIG_US - 1);
  localparam logic [15:0] RISE_LAST = 16'(RISE_TO_US - 1);
  localparam logic [15:0] MAX_LAST  = 16'(MAX_US - 1);
  localparam logic [15:0] MAX_W     = 16'(MAX_US);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_US - 1);

  state_t      state, state_d;
  logic [15:0] pre;
  logic        tick;
  logic [15:0] cnt, cnt_d;
  logic [2:0]  sel, sel_d;
  logic [5:0]  mask_q, mask_d;
  logic [27:0] res_q, res_d;
  logic        done_q, done_d;
  logic [5:0]  echo_meta, echo_sync;
  logic        echo_s, echo_prev;
  logic [5:0]  below;
  logic [3:0]  first_bit, next_bit;

  // Returns {found, index} of the highest set bit.
  function automatic logic [3:0] top_bit(input logic [5:0] m);
    top_bit = '0;
    for (int i = 0; i < 6; i++)
      if (m[i]) top_bit = {1'b1, 3'(i)};
  endfunction

  assign tick      = (pre == PRE_LAST);
  assign echo_s    = echo_sync[sel];
  assign below     = (6'd1 << sel) - 6'd1;
  assign first_bit = top_bit(cfg_mask);
  assign next_bit  = top_bit(mask_q & below);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pre       <= '0;
      cnt       <= '0;
      sel       <= '0;
      mask_q    <= '0;
      res_q     <= '0;
      done_q    <= 1'b0;
      echo_meta <= '0;
      echo_sync <= '0;
      echo_prev <= 1'b0;
    end else begin
      state     <= state_d;
      pre       <= tick ? '0 : pre + 16'd1;
      cnt       <= cnt_d;
      sel       <= sel_d;
      mask_q    <= mask_d;
      res_q     <= res_d;
      done_q    <= done_d;
      echo_meta <= echo;
      echo_sync <= echo_meta;
      echo_prev <= echo_s;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sel_d   = sel;
    mask_d  = mask_q;
    res_d   = res_q;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_wr && cfg_mask != 6'd0) begin
          mask_d  = cfg_mask;
          sel_d   = first_bit[2:0];
          cnt_d   = '0;
          state_d = TRIG;
        end
      end
      TRIG: begin
        if (tick) begin
          if (cnt == TRIG_LAST) begin
            cnt_d   = '0;
            state_d = WAIT_RISE;
          end else cnt_d = cnt + 16'd1;
        end
      end
      WAIT_RISE: begin
        // echo_prev tracks the selected sonar, so an echo already high on entry is no edge
        if (echo_s && !echo_prev) begin
          cnt_d   = '0;
          state_d = MEASURE;
        end else if (tick) begin
          if (cnt == RISE_LAST) begin
            res_d   = {1'b0, sel, 1'b1, 7'd0, 16'hFFFF};
            state_d = OUT;
          end else cnt_d = cnt + 16'd1;
        end
      end
      MEASURE: begin
        if (!echo_s) begin
          res_d   = {1'b0, sel, 1'b0, 7'd0, cnt};
          state_d = OUT;
        end else if (tick) begin
          if (cnt == MAX_LAST) begin
            res_d   = {1'b0, sel, 1'b1, 7'd0, MAX_W};
            state_d = OUT;
          end else cnt_d = cnt + 16'd1;
        end
      end
      OUT: begin
        if (res_ready) begin
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (tick) begin
          if (cnt == GAP_LAST) begin
            cnt_d = '0;
            if (next_bit[3]) begin
              sel_d   = next_bit[2:0];
              state_d = TRIG;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else cnt_d = cnt + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A zero-mask write while busy aborts and overrides any same-cycle acceptance
    if (cfg_wr && cfg_mask == 6'd0 && state != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
  end

  assign trig      = (state == TRIG) ? (6'd1 << sel) : 6'd0;
  assign res_valid = (state == OUT);
  assign res_data  = res_q;
  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_sonar_sequencer.sv
// Directed bench for sonar_sequencer with scaled-down timing parameters and a
// reactive echo model answering each trigger pulse.
module tb_sonar_sequencer;

  localparam int CLK_MHZ = 4;
  localparam int TRIG_US = 10;
  localparam int RISE_US = 100;
  localparam int MAX_US  = 300;
  localparam int GAP_US  = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_wr = 1'b0;
  logic [5:0]  cfg_mask = '0;
  logic [5:0]  trig;
  logic [5:0]  echo;
  logic [27:0] res_data;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic        busy;
  logic        done;
  logic [2:0]  state_dbg;

  int tests = 0;
  int fails = 0;

  // echo model controls (written by the main sequence only)
  logic resp_on = 1'b1;
  int   resp_delay_us = 5;
  int   resp_width_us = 10;

  // trigger monitor
  int         trig_rise[6];
  int         trig_len = 0;
  int         last_trig_len = 0;
  logic [5:0] trig_prev = '0;

  sonar_sequencer #(
    .CLK_MHZ(CLK_MHZ), .TRIG_US(TRIG_US), .RISE_TO_US(RISE_US),
    .MAX_US(MAX_US), .GAP_US(GAP_US)
  ) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_mask(cfg_mask), .trig(trig),
    .echo(echo), .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // echo responder
  initial begin
    int idx;
    echo = '0;
    forever begin
      @(negedge clk);
      if (trig != 6'd0) begin
        idx = 0;
        for (int i = 0; i < 6; i++) if (trig[i]) idx = i;
        for (int k = 0; k < 1000 && trig != 6'd0; k++) @(negedge clk);
        if (resp_on) begin
          repeat (resp_delay_us * CLK_MHZ) @(negedge clk);
          echo[idx] = 1'b1;
          repeat (resp_width_us * CLK_MHZ) @(negedge clk);
          echo[idx] = 1'b0;
        end
      end
    end
  end

  // trigger monitor: rising-edge counts per bit and the length of the last pulse
  initial begin
    for (int i = 0; i < 6; i++) trig_rise[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 6; i++) if (trig[i] && !trig_prev[i]) trig_rise[i]++;
      if (trig != 6'd0) trig_len++;
      else if (trig_prev != 6'd0) begin
        last_trig_len = trig_len;
        trig_len = 0;
      end
      trig_prev = trig;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    tests++;
    assert (obs >= lo && obs <= hi) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // driver tasks
  task automatic start_sweep(input logic [5:0] m);
    @(negedge clk);
    cfg_wr = 1'b1;
    cfg_mask = m;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!res_valid && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
  endtask

  // waits for a result, checks header exactly and width within +/-1, then lets it be accepted
  task automatic expect_result(input string tag, input logic [11:0] hdr, input int width);
    wait_valid(tag);
    check({tag, "_hdr"}, 32'(res_data[27:16]), 32'(hdr));
    check_range({tag, "_width"}, int'(res_data[15:0]), width - 1, width + 1);
    @(negedge clk);
  endtask

  task automatic expect_done(input string tag);
    int n = 0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  // main directed sequence
  initial begin
    int snap[6];
    int cnt;
    logic [27:0] cap;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_trig", 32'(trig), 32'd0);
    check("rst_data", 32'(res_data), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    // zero-mask write while idle does nothing
    start_sweep(6'h00);
    check("idle_zero_busy", 32'(busy), 32'd0);

    // full sweep, 10 us echoes, descending order
    resp_on = 1'b1; resp_delay_us = 5; resp_width_us = 10;
    start_sweep(6'h3F);
    check("full_busy", 32'(busy), 32'd1);
    check("full_first_trig", 32'(trig), 32'h20);
    for (int s = 5; s >= 0; s--)
      expect_result($sformatf("full_s%0d", s), {1'(0), 3'(s), 1'b0, 7'd0}, 10);
    expect_done("full");
    check_range("trig_len", last_trig_len, (TRIG_US - 1) * CLK_MHZ + 1, TRIG_US * CLK_MHZ);

    // sparse mask, 150 us echoes; a nonzero write while busy is ignored
    for (int i = 0; i < 6; i++) snap[i] = trig_rise[i];
    resp_width_us = 150;
    start_sweep(6'h05);
    repeat (10) @(negedge clk);
    start_sweep(6'h3F);
    expect_result("sparse_s2", 12'h200, 150);
    expect_result("sparse_s0", 12'h000, 150);
    expect_done("sparse");
    cnt = 0;
    for (int i = 0; i < 6; i++) cnt += (trig_rise[i] - snap[i]) << (4 * i);
    check("sparse_trig_counts", 32'(cnt), 32'h000101);

    // no echo: rise timeout
    resp_on = 1'b0;
    start_sweep(6'h01);
    for (int k = 0; k < 1000 && trig != 6'd0; k++) @(negedge clk);
    cnt = 0;
    while (trig == 6'd0 && !res_valid && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    check_range("rise_to_len", cnt, (RISE_US - 1) * CLK_MHZ + 1, RISE_US * CLK_MHZ);
    wait_valid("rise_to");
    check("rise_to_data", 32'(res_data), 32'h080FFFF);
    expect_done("rise_to");

    // echo longer than the maximum width
    resp_on = 1'b1; resp_width_us = 400;
    start_sweep(6'h02);
    wait_valid("max");
    check("max_data", 32'(res_data), 32'h180012C);
    expect_done("max");
    repeat (600) @(negedge clk);

    // backpressure: result held, no new trigger, then a full gap after acceptance
    resp_width_us = 10;
    res_ready = 1'b0;
    start_sweep(6'h30);
    wait_valid("bp");
    cap = res_data;
    check("bp_hdr", 32'(cap[27:16]), 32'h500);
    cnt = 0;
    repeat (500 * CLK_MHZ) begin
      @(negedge clk);
      if (res_data !== cap || res_valid !== 1'b1 || trig !== 6'd0) cnt++;
    end
    check("bp_stall", 32'(cnt), 32'd0);
    res_ready = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (trig == 6'd0 && cnt < 1000);
    check_range("gap_len", cnt, (GAP_US - 1) * CLK_MHZ + 2, GAP_US * CLK_MHZ + 1);
    check("gap_next_trig", 32'(trig), 32'h10);
    expect_result("bp_s4", 12'h400, 10);
    expect_done("bp");

    // abort mid-measure
    resp_width_us = 200;
    start_sweep(6'h08);
    cnt = 0;
    while (state_dbg != 3'd3 && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    check("abort_in_measure", 32'(state_dbg), 32'd3);
    repeat (20) @(negedge clk);
    cfg_wr = 1'b1; cfg_mask = 6'h00;
    @(negedge clk);
    cfg_wr = 1'b0;
    check("abort_trig", 32'(trig), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(res_valid), 32'd0);
    check("abort_state", 32'(state_dbg), 32'd0);
    cnt = 0;
    repeat (900) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("abort_no_done", 32'(cnt), 32'd0);

    // abort wins over a same-cycle acceptance
    resp_width_us = 10;
    res_ready = 1'b0;
    start_sweep(6'h01);
    wait_valid("abort_out");
    cfg_wr = 1'b1; cfg_mask = 6'h00; res_ready = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
    check("abort_out_valid", 32'(res_valid), 32'd0);
    check("abort_out_state", 32'(state_dbg), 32'd0);
    cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("abort_out_quiet", 32'(cnt), 32'd0);

    // reset mid-trigger
    resp_on = 1'b0;
    start_sweep(6'h10);
    repeat (5) @(negedge clk);
    check("rst_mid_trig_pre", 32'(trig), 32'h10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_trig", 32'(trig), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_valid", 32'(res_valid), 32'd0);
    check("rst_mid_data", 32'(res_data), 32'd0);
    cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (busy || done || trig != 6'd0) cnt++;
    end
    check("rst_mid_quiet", 32'(cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
